// File: rtl/subword_mem_sequencer_if.sv
// Bundle between the MEM stage / datapath controller, the sequencer and the
// word-wide data memory. The slave modport is the sequencer's view.
interface subword_mem_sequencer_if #(
   parameter int AW = 30
);
   logic          start;
   logic [2:0]    memop;
   logic [31:0]   addr;
   logic [31:0]   writedata;
   logic          stall;
   logic          done;
   logic          addrerr;
   logic [31:0]   readdata;
   logic [AW-1:0] memaddr;
   logic          memread;
   logic          memwrite;
   logic [31:0]   memwrdata;
   logic [31:0]   memrddata;

   modport slave (
      input  start, memop, addr, writedata, memrddata,
      output stall, done, addrerr, readdata, memaddr, memread, memwrite, memwrdata
   );

   modport master (
      output start, memop, addr, writedata, memrddata,
      input  stall, done, addrerr, readdata, memaddr, memread, memwrite, memwrdata
   );
endinterface

// File: rtl/subword_mem_sequencer.sv
// Multi-cycle MEM-stage controller for byte/half/word loads and stores on a
// word-wide memory; sub-word stores are done as read-modify-write.
module subword_mem_sequencer #(
   parameter int RD_LAT = 1,
   parameter int AW     = 30
) (
   input logic                  clk,
   input logic                  rst,
   subword_mem_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } memop_t;

   localparam int CNT_W = 3;

   state_t        state_q, state_d;
   memop_t        op_q;
   memop_t        op_in;
   logic [1:0]    lane_q;
   logic [15:0]   wdata_q;
   logic          err_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]   readdata_q;
   logic [31:0]   memwrdata_q;
   logic [AW-1:0] memaddr_q;
   logic          accept;
   logic          misaligned;
   logic          last_wait;

   function automatic logic is_load(input memop_t op);
      return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic check_misaligned(input memop_t op, input logic [1:0] a);
      case (op)
         OP_LW, OP_SW:          return a != 2'b00;
         OP_LH, OP_LHU, OP_SH:  return a[0];
         default:               return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input memop_t op, input logic [1:0] lane,
                                               input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input memop_t op, input logic [1:0] lane,
                                               input logic [31:0] w, input logic [15:0] wd);
      logic [31:0] r;
      r = w;
      if (op == OP_SB)
         r[{lane, 3'b000} +: 8] = wd[7:0];
      else if (lane[1])
         r[31:16] = wd;
      else
         r[15:0] = wd;
      return r;
   endfunction

   assign op_in      = memop_t'(bus.memop);
   assign accept     = (state_q == IDLE) && bus.start;
   assign misaligned = check_misaligned(op_in, bus.addr[1:0]);
   assign last_wait  = (state_q == WAIT) && (cnt_q == CNT_W'(RD_LAT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      bus.stall     = 1'b0;
      bus.done      = 1'b0;
      bus.addrerr   = 1'b0;
      bus.memread   = 1'b0;
      bus.memwrite  = 1'b0;
      case (state_q)
         IDLE: begin
            bus.stall = bus.start & rst;
            if (bus.start) begin
               if (misaligned)          state_d = DONE;
               else if (op_in == OP_SW) state_d = WR;
               else                     state_d = RD;
            end
         end
         RD: begin
            bus.stall   = 1'b1;
            bus.memread = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            bus.stall = 1'b1;
            if (last_wait) state_d = is_load(op_q) ? DONE : WR;
         end
         WR: begin
            bus.stall    = 1'b1;
            bus.memwrite = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            bus.done    = 1'b1;
            bus.addrerr = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, wait counter, load capture and store merge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q        <= OP_LW;
         lane_q      <= 2'b00;
         wdata_q     <= 16'h0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         readdata_q  <= 32'h0;
         memwrdata_q <= 32'h0;
         memaddr_q   <= '0;
      end else begin
         if (accept) begin
            op_q    <= op_in;
            lane_q  <= bus.addr[1:0];
            wdata_q <= bus.writedata[15:0];
            err_q   <= misaligned;
            // A rejected access leaves the memory-side registers untouched.
            if (!misaligned) begin
               memaddr_q <= bus.addr[AW+1:2];
               if (op_in == OP_SW) memwrdata_q <= bus.writedata;
            end
         end

         if (state_q == RD)        cnt_q <= '0;
         else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;

         if (last_wait) begin
            if (is_load(op_q)) readdata_q  <= load_extend(op_q, lane_q, bus.memrddata);
            else               memwrdata_q <= store_merge(op_q, lane_q, bus.memrddata, wdata_q);
         end
      end
   end

   assign bus.readdata  = readdata_q;
   assign bus.memwrdata = memwrdata_q;
   assign bus.memaddr   = memaddr_q;

endmodule

// File: tb/tb_subword_mem_sequencer.sv
// Directed scoreboard bench: one sequencer with RD_LAT=1 and one with
// RD_LAT=3, each backed by a latency-accurate word memory model.
module tb_subword_mem_sequencer;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [29:0] waddr;
      logic [31:0] wdata;
      int          wcyc;
   } exp_t;

   localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                          LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, sel;
   logic [2:0]  memop;
   logic [31:0] addr, wdata;

   logic        bd_we;
   logic [5:0]  bd_a;
   logic [31:0] bd_d;
   logic [31:0] mem [0:63];

   logic        p0_v;
   logic [5:0]  p0_a;
   logic [2:0]  p1_v;
   logic [5:0]  p1_a [0:2];

   logic        o_stall, o_done, o_err, o_mrd, o_mwr;
   logic [31:0] o_rd, o_wd;
   logic [29:0] o_ma;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   subword_mem_sequencer_if #(.AW(30)) if0 ();
   subword_mem_sequencer_if #(.AW(30)) if1 ();

   subword_mem_sequencer #(.RD_LAT(1), .AW(30)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   subword_mem_sequencer #(.RD_LAT(3), .AW(30)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   assign if0.start     = start & ~sel;
   assign if1.start     = start & sel;
   assign if0.memop     = memop;
   assign if1.memop     = memop;
   assign if0.addr      = addr;
   assign if1.addr      = addr;
   assign if0.writedata = wdata;
   assign if1.writedata = wdata;

   assign o_stall = sel ? if1.stall     : if0.stall;
   assign o_done  = sel ? if1.done      : if0.done;
   assign o_err   = sel ? if1.addrerr   : if0.addrerr;
   assign o_mrd   = sel ? if1.memread   : if0.memread;
   assign o_mwr   = sel ? if1.memwrite  : if0.memwrite;
   assign o_rd    = sel ? if1.readdata  : if0.readdata;
   assign o_wd    = sel ? if1.memwrdata : if0.memwrdata;
   assign o_ma    = sel ? if1.memaddr   : if0.memaddr;

   // Memory model: read data is valid only in the cycle RD_LAT cycles after
   // the read strobe; any other cycle returns a poison word.
   always @(posedge clk) begin
      if (bd_we)        mem[bd_a] <= bd_d;
      if (if0.memwrite) mem[if0.memaddr[5:0]] <= if0.memwrdata;
      if (if1.memwrite) mem[if1.memaddr[5:0]] <= if1.memwrdata;
      p0_v    <= if0.memread;
      p0_a    <= if0.memaddr[5:0];
      p1_v    <= {p1_v[1:0], if1.memread};
      p1_a[0] <= if1.memaddr[5:0];
      p1_a[1] <= p1_a[0];
      p1_a[2] <= p1_a[1];
   end

   assign if0.memrddata = (p0_v === 1'b1)    ? mem[p0_a]    : 32'hDEAD_BEEF;
   assign if1.memrddata = (p1_v[2] === 1'b1) ? mem[p1_a[2]] : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic poke(input int w, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1;
      bd_a  = w[5:0];
      bd_d  = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] e_rd, input logic e_err,
                         input int e_lat, input int e_nrd, input int e_nwr,
                         input logic [29:0] e_waddr, input logic [31:0] e_wdata,
                         input int e_wcyc, input bit poke_mid);
      exp_t        e;
      int          lat, nrd, nwr, wcyc;
      logic        stall_ok, stall_done, err_seen;
      logic [31:0] rd_seen, wd_seen;
      logic [29:0] wa_seen;
      e = '{rd: e_rd, err: e_err, lat: e_lat, nrd: e_nrd, nwr: e_nwr,
            waddr: e_waddr, wdata: e_wdata, wcyc: e_wcyc};
      sb_q.push_back(e);
      lat = -1; nrd = 0; nwr = 0; wcyc = -1;
      stall_ok = 1'b1; stall_done = 1'bx; err_seen = 1'bx;
      rd_seen = 'x; wd_seen = 'x; wa_seen = 'x;

      @(negedge clk);
      memop = op; addr = a; wdata = wd; start = 1'b1;
      #1 check({tag, ".stall_c0"}, 32'(o_stall), 32'd1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = poke_mid && (k == 3);
         #1;
         if (o_mrd) nrd++;
         if (o_mwr) begin
            nwr++;
            wcyc    = k;
            wd_seen = o_wd;
            wa_seen = o_ma;
         end
         if (o_done) begin
            lat        = k;
            rd_seen    = o_rd;
            err_seen   = o_err;
            stall_done = o_stall;
            break;
         end
         if (!o_stall) stall_ok = 1'b0;
      end
      start = 1'b0;

      e = sb_q.pop_front();
      check({tag, ".done_cycle"}, 32'(lat), 32'(e.lat));
      check({tag, ".addrerr"}, 32'(err_seen), 32'(e.err));
      check({tag, ".readdata"}, rd_seen, e.rd);
      check({tag, ".memread_cnt"}, 32'(nrd), 32'(e.nrd));
      check({tag, ".memwrite_cnt"}, 32'(nwr), 32'(e.nwr));
      check({tag, ".stall_busy"}, 32'(stall_ok), 32'd1);
      check({tag, ".stall_done"}, 32'(stall_done), 32'd0);
      if (e.nwr > 0) begin
         check({tag, ".wr_cycle"}, 32'(wcyc), 32'(e.wcyc));
         check({tag, ".wr_addr"}, 32'(wa_seen), 32'(e.waddr));
         check({tag, ".wr_data"}, wd_seen, e.wdata);
      end
      @(negedge clk);
      #1;
      check({tag, ".idle_stall"}, 32'(o_stall), 32'd0);
      check({tag, ".idle_done"}, 32'(o_done), 32'd0);
   endtask

   initial begin
      int nwr_rst;
      rst = 1'b0; start = 1'b0; sel = 1'b0; bd_we = 1'b0;
      bd_a = '0; bd_d = '0; memop = LW; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst.stall", 32'(o_stall), 32'd0);
      check("rst.done", 32'(o_done), 32'd0);
      check("rst.memread", 32'(o_mrd), 32'd0);
      check("rst.memwrite", 32'(o_mwr), 32'd0);
      check("rst.readdata", o_rd, 32'h0);
      check("rst.memaddr", 32'(o_ma), 32'h0);
      check("rst.memwrdata", o_wd, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // RD_LAT=1 loads and extension
      poke(4, 32'hA1B2_C3D4);
      run_op("lw",  LW,  32'h10, 32'h0, 32'hA1B2_C3D4, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      poke(4, 32'h80FF_7F01);
      run_op("lb3",  LB,  32'h13, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lbu3", LBU, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lh2",  LH,  32'h12, 32'h0, 32'hFFFF_80FF, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lhu0", LHU, 32'h10, 32'h0, 32'h0000_7F01, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lb2",  LB,  32'h12, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 1, 0, 30'd0, 32'h0, 0, 1'b0);

      // Read-modify-write byte store; readdata keeps the last load result
      poke(4, 32'h1122_3344);
      run_op("sb1", SB, 32'h11, 32'hAAAA_AA55, 32'hFFFF_FFFF, 1'b0, 4, 1, 1,
             30'd4, 32'h1122_5544, 3, 1'b0);
      check("sb1.mem", mem[4], 32'h1122_5544);

      // Misaligned accesses: no memory traffic, readdata unchanged
      run_op("sh_mis", SH,  32'h13, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1, 0, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lw_mis", LW,  32'h02, 32'h0,    32'hFFFF_FFFF, 1'b1, 1, 0, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("lhu_mis", LHU, 32'h05, 32'h0,   32'hFFFF_FFFF, 1'b1, 1, 0, 0, 30'd0, 32'h0, 0, 1'b0);
      check("mis.mem", mem[4], 32'h1122_5544);

      // RD_LAT=3 path, with a stray Start pulse during WAIT
      sel = 1'b1;
      poke(4, 32'h1122_3344);
      run_op("sh_l3", SH, 32'h10, 32'hFFFF_BEEF, 32'h0, 1'b0, 6, 1, 1,
             30'd4, 32'h1122_BEEF, 5, 1'b1);
      run_op("lw_l3", LW, 32'h10, 32'h0, 32'h1122_BEEF, 1'b0, 5, 1, 0, 30'd0, 32'h0, 0, 1'b0);
      run_op("sh_hi", SH, 32'h12, 32'h0000_1234, 32'h1122_BEEF, 1'b0, 6, 1, 1,
             30'd4, 32'h1234_BEEF, 5, 1'b0);
      check("l3.mem", mem[4], 32'h1234_BEEF);

      // Reset during WAIT of an SB: outputs clear at once and nothing is written
      poke(5, 32'h1122_3344);
      @(negedge clk);
      memop = SB; addr = 32'h15; wdata = 32'h99; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst.stall", 32'(o_stall), 32'd0);
      check("mid_rst.done", 32'(o_done), 32'd0);
      check("mid_rst.addrerr", 32'(o_err), 32'd0);
      check("mid_rst.memread", 32'(o_mrd), 32'd0);
      check("mid_rst.memwrite", 32'(o_mwr), 32'd0);
      check("mid_rst.readdata", o_rd, 32'h0);
      check("mid_rst.memaddr", 32'(o_ma), 32'h0);
      check("mid_rst.memwrdata", o_wd, 32'h0);
      nwr_rst = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) rst = 1'b1;
         #1;
         if (o_mwr) nwr_rst++;
      end
      check("mid_rst.no_write", 32'(nwr_rst), 32'd0);
      check("mid_rst.mem", mem[5], 32'h1122_3344);

      // Fresh SW after reset completes in two cycles
      sel = 1'b0;
      run_op("sw_post", SW, 32'h18, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 0, 1,
             30'd6, 32'hCAFE_F00D, 1, 1'b0);
      @(negedge clk);
      check("sw_post.mem", mem[6], 32'hCAFE_F00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
